pow2_check_arbiter: RTL
=======================

# pow2_check_arbiter

Time-shares a single exactly-one-bit-set (power-of-two) detector among `N_REQ` requesters. Requesters present bytes with a valid/ready handshake, and a round-robin arbiter grants one at a time. The captured byte is classified, and the result is returned with requester ID, bit index and a running power-of-two count under output backpressure. It sits between the byte producers of the Potenze2 datapath and any consumer of classification results.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 8: data width in bits.
- `IDW`, $clog2(N_REQ): requester ID width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester data valid.
- `req_data`  in  N_REQ*W  requester i data in bits [i*W +: W].
- `req_ready`  out  N_REQ  grant/accept, at most one bit high.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_id`  out  IDW  requester ID of result.
- `out_data`  out  W  byte that was classified.
- `out_pow2`  out  1  1 iff exactly one bit of `out_data` is set.
- `out_log2`  out  $clog2(W)  index of the set bit when `out_pow2`=1, else 0.
- `pow2_count`  out  16  accepted results with `out_pow2`=1, saturating.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, CHECK, RESULT.
- **IDLE**
  - `grant` = first i with `req_valid[i]`=1, scanning `ptr`, `ptr+1`, … modulo N_REQ.
  - `req_ready[grant]`=1 combinationally. All other `req_ready` bits are 0. If no request is valid, all are 0.
  - On handshake, capture `req_data` of `grant` into `cap_data`, set `cap_id`=`grant`, set `ptr` <= (`grant`+1) mod N_REQ, and go to CHECK.
- **CHECK**
  - The shared detector evaluates `cap_data`.
  - `out_pow2` = (popcount==1). Zero is not a power of two; all-ones is not a power of two.
  - `out_log2` = the bit index i, where bit i has weight 2^i.
  - Register `out_data`, `out_id`, `out_pow2`, `out_log2`. Set `out_valid`=1 and go to RESULT.
- **RESULT**
  - Hold all `out_*` stable while `out_ready`=0.
  - On `out_valid`&&`out_ready`: clear `out_valid`, go to IDLE, and if `out_pow2`=1 increment `pow2_count` unless it is already 16'hFFFF.
- `req_ready` is 0 in CHECK and RESULT. Requests may stay asserted, and their data must stay stable until accepted.
- The detector is used only in CHECK; exactly one evaluation per granted transaction.
- Reset (`rst_n`=0 at an edge), in any state:
  - state=IDLE, `ptr`=0, `out_valid`=0, `out_id`=0, `out_data`=0, `out_pow2`=0, `out_log2`=0, `pow2_count`=0, `busy`=0.
  - `req_ready`=0 while `rst_n`=0.
  - An in-flight transaction is dropped with no result.

## Timing
- Edge E0: request handshake in IDLE.
- Edge E1: result registered; `out_valid`=1 from E1.
- Edge E2 earliest: result accepted. Back in IDLE after E2.
- Next grant at E3 at the earliest. Peak throughput is 1 result per 3 cycles.
- Latency from handshake to `out_valid` is 1 cycle; stalls extend RESULT indefinitely.
- The `ptr` update happens at the grant edge. A requester just served has lowest priority at the next arbitration.
- `pow2_count` updates on the same edge as output acceptance.
- A new request arriving in the same cycle as `out_ready` is not granted until the cycle after return to IDLE.

## Test plan
- **Reset values:** reset for 2 cycles with all `req_valid`=1 → `req_ready`=0 and all outputs 0. After release, first grant is to requester 0.
- **Single request:** requester 2 sends 8'h10 with `out_ready`=1 → `out_valid` 1 cycle after handshake, `out_id`=2, `out_pow2`=1, `out_log2`=4. `pow2_count` becomes 1.
- **Non-powers:** sequence 8'h00, 8'h03, 8'hFF, 8'h80 from requester 0 → `out_pow2`=0,0,0,1; `out_log2`=0,0,0,7. `pow2_count` ends at 1.
- **Round-robin fairness:** all 4 requesters continuously valid → grant order 0,1,2,3,0,1…, with no requester served twice before the others are served once.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in RESULT → outputs stable, `req_ready` all 0, no new capture. Accept on cycle 6, then the next grant follows.
- **Reset mid-transaction and saturation:** reset in CHECK → no result emitted and `ptr`=0. Separately, preload the count to 16'hFFFE via 2 extra accepted powers → count stays at 16'hFFFF.

Source files
------------

// File: rtl/pow2_check_arbiter.sv
// pow2_check_arbiter: a round-robin arbiter in front of one shared
// power-of-two detector. Each granted byte is classified in the CHECK
// state. The result is then held in RESULT until the consumer accepts it.
module pow2_check_arbiter #(
    parameter int          N_REQ       = 4,
    parameter int          W           = 8,
    parameter int          IDW         = $clog2(N_REQ),
    parameter int          LW          = $clog2(W),
    // Value loaded into the result counter on reset. It is zero in normal
    // use; a non-zero value lets the saturation point be reached quickly.
    parameter logic [15:0] CNT_RST_VAL = 16'h0000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ*W-1:0] i_req_data,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [IDW-1:0]     o_out_id,
    output logic [W-1:0]       o_out_data,
    output logic               o_out_pow2,
    output logic [LW-1:0]      o_out_log2,
    output logic [15:0]        o_pow2_count,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [W-1:0]       r_cap_data;
    logic [IDW-1:0]     r_cap_id;
    logic               r_out_valid;
    logic [IDW-1:0]     r_out_id;
    logic [W-1:0]       r_out_data;
    logic               r_out_pow2;
    logic [LW-1:0]      r_out_log2;
    logic [15:0]        r_pow2_count;

    logic [IDW-1:0]     w_grant;
    logic               w_grant_vld;
    logic [N_REQ-1:0]   w_req_ready;
    logic [W-1:0]       w_sel_data;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic f_is_pow2(input logic [W-1:0] d);
        return (d != {W{1'b0}}) && ((d & (d - W'(1'b1))) == {W{1'b0}});
    endfunction

    // Index of the highest set bit. For a one-hot value this is its only bit.
    function automatic logic [LW-1:0] f_bit_index(input logic [W-1:0] d);
        logic [LW-1:0] v_idx;
        v_idx = {LW{1'b0}};
        for (int i = 0; i < W; i++) begin
            v_idx = d[i] ? LW'(i) : v_idx;
        end
        return v_idx;
    endfunction

    // Round-robin pick: first valid requester scanning from r_ptr upward with wrap.
    always_comb begin
        w_grant     = {IDW{1'b0}};
        w_grant_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            logic [IDW-1:0] v_idx;
            logic           v_hit;
            v_idx       = IDW'((int'(r_ptr) + k) % N_REQ);
            v_hit       = i_req_valid[v_idx] & ~w_grant_vld;
            w_grant     = v_hit ? v_idx : w_grant;
            w_grant_vld = w_grant_vld | v_hit;
        end
    end

    // Grant is offered only in IDLE and never while reset is asserted.
    always_comb begin
        w_req_ready = {N_REQ{1'b0}};
        if ((r_state == S_IDLE) && i_rst_n && w_grant_vld) begin
            w_req_ready[w_grant] = 1'b1;
        end else begin
            w_req_ready = {N_REQ{1'b0}};
        end
    end

    assign w_sel_data = i_req_data[w_grant*W +: W];

    // Main controller: capture on grant, classify once, then hold the result until it is accepted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= {IDW{1'b0}};
            r_cap_data   <= {W{1'b0}};
            r_cap_id     <= {IDW{1'b0}};
            r_out_valid  <= 1'b0;
            r_out_id     <= {IDW{1'b0}};
            r_out_data   <= {W{1'b0}};
            r_out_pow2   <= 1'b0;
            r_out_log2   <= {LW{1'b0}};
            r_pow2_count <= CNT_RST_VAL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_cap_data <= w_sel_data;
                        r_cap_id   <= w_grant;
                        // The requester just served drops to lowest priority.
                        r_ptr      <= (w_grant == IDW'(N_REQ - 1)) ? {IDW{1'b0}}
                                                                   : w_grant + IDW'(1'b1);
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_out_data  <= r_cap_data;
                    r_out_id    <= r_cap_id;
                    r_out_pow2  <= f_is_pow2(r_cap_data);
                    r_out_log2  <= f_is_pow2(r_cap_data) ? f_bit_index(r_cap_data)
                                                         : {LW{1'b0}};
                    r_out_valid <= 1'b1;
                    r_state     <= S_RESULT;
                end
                S_RESULT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        if (r_out_pow2 && (r_pow2_count != 16'hFFFF)) begin
                            r_pow2_count <= r_pow2_count + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = w_req_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_id     = r_out_id;
    assign o_out_data   = r_out_data;
    assign o_out_pow2   = r_out_pow2;
    assign o_out_log2   = r_out_log2;
    assign o_pow2_count = r_pow2_count;
    assign o_busy       = (r_state != S_IDLE);

endmodule
